// File: rtl/axi_conf.sv
// Shared AXI configuration types.
// Response codes and error-responder FSM states.
package axi_conf;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_trans_resp_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } axi_err_wstate_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } axi_err_rstate_e;

endpackage

// File: rtl/axi_err_responder.sv
// AXI4 subordinate terminating denied transactions.
// Answers every write and read burst with a fixed error code.
module axi_err_responder
    import axi_conf::*;
#(
    parameter int unsigned     IdWidth   = 4,
    parameter int unsigned     DataWidth = 64,
    parameter axi_trans_resp_t Resp      = RESP_DECERR
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 aw_valid_i,
    output logic                 aw_ready_o,
    input  logic [IdWidth-1:0]   aw_id_i,
    input  logic                 w_valid_i,
    output logic                 w_ready_o,
    input  logic                 w_last_i,
    output logic                 b_valid_o,
    input  logic                 b_ready_i,
    output logic [IdWidth-1:0]   b_id_o,
    output logic [1:0]           b_resp_o,
    input  logic                 ar_valid_i,
    output logic                 ar_ready_o,
    input  logic [IdWidth-1:0]   ar_id_i,
    input  logic [7:0]           ar_len_i,
    output logic                 r_valid_o,
    input  logic                 r_ready_i,
    output logic [IdWidth-1:0]   r_id_o,
    output logic [DataWidth-1:0] r_data_o,
    output logic [1:0]           r_resp_o,
    output logic                 r_last_o
);

    if (Resp != RESP_SLVERR && Resp != RESP_DECERR) begin : g_bad_resp
        $error("axi_err_responder: Resp must be SLVERR or DECERR");
    end

    axi_err_wstate_e w_state_q, w_state_d;
    logic [IdWidth-1:0] aw_id_q, aw_id_d;

    axi_err_rstate_e r_state_q, r_state_d;
    logic [IdWidth-1:0] ar_id_q, ar_id_d;
    logic [7:0] r_cnt_q, r_cnt_d;

    // Write path state register and captured AW ID.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            w_state_q <= W_IDLE;
            aw_id_q   <= '0;
        end else begin
            w_state_q <= w_state_d;
            aw_id_q   <= aw_id_d;
        end
    end

    // Write path next state: take AW, swallow W beats, emit one B.
    always_comb begin
        w_state_d = w_state_q;
        aw_id_d   = aw_id_q;
        unique case (w_state_q)
            W_IDLE: begin
                if (aw_valid_i) begin
                    aw_id_d   = aw_id_i;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (w_valid_i && w_last_i) begin
                    w_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (b_ready_i) begin
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read path state register, captured AR ID and beat counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state_q <= R_IDLE;
            ar_id_q   <= '0;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            ar_id_q   <= ar_id_d;
            r_cnt_q   <= r_cnt_d;
        end
    end

    // Read path next state: count down len+1 beats, stop at zero.
    always_comb begin
        r_state_d = r_state_q;
        ar_id_d   = ar_id_q;
        r_cnt_d   = r_cnt_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (ar_valid_i) begin
                    ar_id_d   = ar_id_i;
                    r_cnt_d   = ar_len_i;
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (r_ready_i) begin
                    if (r_cnt_q != 8'd0) begin
                        r_cnt_d = r_cnt_q - 8'd1;
                    end else begin
                        r_state_d = R_IDLE;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    assign aw_ready_o = (w_state_q == W_IDLE);
    assign w_ready_o  = (w_state_q == W_DATA);
    assign b_valid_o  = (w_state_q == W_RESP);
    assign b_id_o     = aw_id_q;
    assign b_resp_o   = Resp;

    assign ar_ready_o = (r_state_q == R_IDLE);
    assign r_valid_o  = (r_state_q == R_DATA);
    assign r_last_o   = (r_state_q == R_DATA) && (r_cnt_q == 8'd0);
    assign r_id_o     = ar_id_q;
    assign r_data_o   = '0;
    assign r_resp_o   = Resp;

endmodule

// File: tb/tb_axi_err_responder.sv
// Directed bench for axi_err_responder.
// Two instances share inputs: DECERR (default) and SLVERR.
module tb_axi_err_responder;
    import axi_conf::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       aw_valid, w_valid, w_last, b_ready;
    logic       ar_valid, r_ready;
    logic [3:0] aw_id, ar_id;
    logic [7:0] ar_len;

    logic        aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last;
    logic [3:0]  b_id, r_id;
    logic [1:0]  b_resp, r_resp;
    logic [63:0] r_data;

    logic        s_aw_ready, s_w_ready, s_b_valid, s_ar_ready;
    logic        s_r_valid, s_r_last;
    logic [3:0]  s_b_id, s_r_id;
    logic [1:0]  s_b_resp, s_r_resp;
    logic [63:0] s_r_data;

    int checks = 0;
    int errors = 0;

    axi_err_responder u_dec (
        .clk_i(clk), .rst_ni(rst_n),
        .aw_valid_i(aw_valid), .aw_ready_o(aw_ready), .aw_id_i(aw_id),
        .w_valid_i(w_valid), .w_ready_o(w_ready), .w_last_i(w_last),
        .b_valid_o(b_valid), .b_ready_i(b_ready), .b_id_o(b_id),
        .b_resp_o(b_resp),
        .ar_valid_i(ar_valid), .ar_ready_o(ar_ready), .ar_id_i(ar_id),
        .ar_len_i(ar_len),
        .r_valid_o(r_valid), .r_ready_i(r_ready), .r_id_o(r_id),
        .r_data_o(r_data), .r_resp_o(r_resp), .r_last_o(r_last)
    );

    axi_err_responder #(.Resp(RESP_SLVERR)) u_slv (
        .clk_i(clk), .rst_ni(rst_n),
        .aw_valid_i(aw_valid), .aw_ready_o(s_aw_ready), .aw_id_i(aw_id),
        .w_valid_i(w_valid), .w_ready_o(s_w_ready), .w_last_i(w_last),
        .b_valid_o(s_b_valid), .b_ready_i(b_ready), .b_id_o(s_b_id),
        .b_resp_o(s_b_resp),
        .ar_valid_i(ar_valid), .ar_ready_o(s_ar_ready), .ar_id_i(ar_id),
        .ar_len_i(ar_len),
        .r_valid_o(s_r_valid), .r_ready_i(r_ready), .r_id_o(s_r_id),
        .r_data_o(s_r_data), .r_resp_o(s_r_resp), .r_last_o(s_r_last)
    );

    task automatic test_reset();
        rst_n = 1'b0;
        aw_valid = 0; w_valid = 0; w_last = 0; b_ready = 0;
        ar_valid = 0; r_ready = 0; aw_id = 0; ar_id = 0; ar_len = 0;
        repeat (2) @(negedge clk);
        checks++;
        if ({aw_ready, ar_ready} !== 2'b11) begin
            errors++;
            $display("FAIL reset_ready got=%b exp=11", {aw_ready, ar_ready});
        end
        checks++;
        if ({w_ready, b_valid, r_valid, r_last} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_valids got=%b exp=0000",
                     {w_ready, b_valid, r_valid, r_last});
        end
        checks++;
        if (b_id !== 4'd0 || r_id !== 4'd0 || r_data !== 64'd0) begin
            errors++;
            $display("FAIL reset_ids b_id=%0d r_id=%0d r_data=%0h exp=0",
                     b_id, r_id, r_data);
        end
        checks++;
        if (b_resp !== 2'b11 || r_resp !== 2'b11) begin
            errors++;
            $display("FAIL reset_resp b=%b r=%b exp=11", b_resp, r_resp);
        end
        checks++;
        if (s_b_resp !== 2'b10 || s_r_resp !== 2'b10) begin
            errors++;
            $display("FAIL reset_slv_resp b=%b r=%b exp=10",
                     s_b_resp, s_r_resp);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        b_ready = 1; aw_valid = 1; aw_id = 4'd3;
        @(negedge clk);
        checks++;
        if (w_ready !== 1'b1 || aw_ready !== 1'b0) begin
            errors++;
            $display("FAIL wr_after_aw w_ready=%b aw_ready=%b exp=1/0",
                     w_ready, aw_ready);
        end
        aw_valid = 0;
        for (int i = 0; i < 4; i++) begin
            w_valid = 1; w_last = (i == 3);
            @(negedge clk);
            if (i < 3) begin
                checks++;
                if (b_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL wr_early_b beat=%0d got=%b exp=0",
                             i, b_valid);
                end
            end
        end
        w_valid = 0; w_last = 0;
        checks++;
        if (b_valid !== 1'b1 || b_id !== 4'd3 || b_resp !== 2'b11
            || w_ready !== 1'b0) begin
            errors++;
            $display("FAIL wr_b v=%b id=%0d resp=%b wr=%b exp=1/3/11/0",
                     b_valid, b_id, b_resp, w_ready);
        end
        @(negedge clk);
        checks++;
        if (b_valid !== 1'b0 || aw_ready !== 1'b1) begin
            errors++;
            $display("FAIL wr_done b_valid=%b aw_ready=%b exp=0/1",
                     b_valid, aw_ready);
        end
    endtask

    task automatic test_read();
        r_ready = 1; ar_valid = 1; ar_id = 4'd5; ar_len = 8'd7;
        @(negedge clk);
        ar_valid = 0;
        for (int b = 0; b < 8; b++) begin
            checks++;
            if (r_valid !== 1'b1 || r_id !== 4'd5 || r_data !== 64'd0
                || r_resp !== 2'b11 || r_last !== (b == 7)
                || ar_ready !== 1'b0) begin
                errors++;
                $display("FAIL rd_beat%0d v=%b id=%0d d=%0h resp=%b last=%b ar=%b",
                         b, r_valid, r_id, r_data, r_resp, r_last, ar_ready);
            end
            @(negedge clk);
        end
        checks++;
        if (r_valid !== 1'b0 || ar_ready !== 1'b1) begin
            errors++;
            $display("FAIL rd_done r_valid=%b ar_ready=%b exp=0/1",
                     r_valid, ar_ready);
        end
    endtask

    task automatic test_backpressure();
        int k;
        b_ready = 0; r_ready = 0;
        aw_valid = 1; aw_id = 4'd6;
        ar_valid = 1; ar_id = 4'd7; ar_len = 8'd2;
        @(negedge clk);
        aw_valid = 0; ar_valid = 0;
        w_valid = 1; w_last = 1;
        @(negedge clk);
        w_valid = 0; w_last = 0;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (s_b_valid !== 1'b1 || s_aw_ready !== 1'b0
                || s_b_id !== 4'd6 || s_b_resp !== 2'b10) begin
                errors++;
                $display("FAIL bp_hold c=%0d v=%b aw=%b id=%0d resp=%b",
                         c, s_b_valid, s_aw_ready, s_b_id, s_b_resp);
            end
            @(negedge clk);
        end
        b_ready = 1;
        @(negedge clk);
        b_ready = 0;
        checks++;
        if (s_b_valid !== 1'b0 || s_aw_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release v=%b aw=%b exp=0/1",
                     s_b_valid, s_aw_ready);
        end
        k = 0;
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (s_r_valid !== (k < 3) || s_ar_ready !== (k == 3)) begin
                errors++;
                $display("FAIL bp_rvalid c=%0d v=%b ar=%b beat=%0d",
                         c, s_r_valid, s_ar_ready, k);
            end
            if (k < 3) begin
                checks++;
                if (s_r_last !== (k == 2) || s_r_id !== 4'd7
                    || s_r_resp !== 2'b10 || s_r_data !== 64'd0) begin
                    errors++;
                    $display("FAIL bp_rbeat c=%0d last=%b id=%0d resp=%b",
                             c, s_r_last, s_r_id, s_r_resp);
                end
            end
            r_ready = c[0];
            if (r_ready && k < 3) k++;
            @(negedge clk);
        end
        r_ready = 0;
    endtask

    task automatic test_simultaneous();
        b_ready = 1; r_ready = 1;
        aw_valid = 1; aw_id = 4'd1;
        ar_valid = 1; ar_id = 4'd2; ar_len = 8'd0;
        @(negedge clk);
        aw_valid = 0; ar_valid = 0;
        checks++;
        if (aw_ready !== 1'b0 || w_ready !== 1'b1 || ar_ready !== 1'b0
            || b_valid !== 1'b0) begin
            errors++;
            $display("FAIL sim_accept aw=%b w=%b ar=%b b=%b exp=0/1/0/0",
                     aw_ready, w_ready, ar_ready, b_valid);
        end
        checks++;
        if (r_valid !== 1'b1 || r_last !== 1'b1 || r_id !== 4'd2) begin
            errors++;
            $display("FAIL sim_rbeat v=%b last=%b id=%0d exp=1/1/2",
                     r_valid, r_last, r_id);
        end
        @(negedge clk);
        checks++;
        if (r_valid !== 1'b0 || ar_ready !== 1'b1 || w_ready !== 1'b1) begin
            errors++;
            $display("FAIL sim_after v=%b ar=%b w=%b exp=0/1/1",
                     r_valid, ar_ready, w_ready);
        end
        w_valid = 1; w_last = 1;
        @(negedge clk);
        w_valid = 0; w_last = 0;
        checks++;
        if (b_valid !== 1'b1 || b_id !== 4'd1) begin
            errors++;
            $display("FAIL sim_b v=%b id=%0d exp=1/1", b_valid, b_id);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_burst();
        int beats;
        int lasts;
        r_ready = 1;
        ar_valid = 1; ar_id = 4'd4; ar_len = 8'd7;
        @(negedge clk);
        ar_valid = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (r_valid !== 1'b1 || r_id !== 4'd4) begin
            errors++;
            $display("FAIL mid_pre v=%b id=%0d exp=1/4", r_valid, r_id);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (r_valid !== 1'b0 || r_last !== 1'b0 || ar_ready !== 1'b1
            || aw_ready !== 1'b1 || r_id !== 4'd0) begin
            errors++;
            $display("FAIL mid_rst v=%b last=%b ar=%b aw=%b id=%0d",
                     r_valid, r_last, ar_ready, aw_ready, r_id);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        ar_valid = 1; ar_id = 4'd9; ar_len = 8'd1;
        @(negedge clk);
        ar_valid = 0;
        beats = 0; lasts = 0;
        for (int c = 0; c < 5; c++) begin
            if (r_valid === 1'b1) begin
                beats++;
                if (r_last === 1'b1) lasts = beats;
            end
            @(negedge clk);
        end
        checks++;
        if (beats != 2 || lasts != 2) begin
            errors++;
            $display("FAIL mid_new beats=%0d last_at=%0d exp=2/2",
                     beats, lasts);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_backpressure();
        test_simultaneous();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_err_responder.md
# axi_err_responder

AXI4 subordinate that terminates transactions the IO-PMP has denied, answering each with a fixed error response. Sits behind the IO-PMP demultiplexer on the "denied" branch. It accepts and discards all write data, returns a single B response per write, and returns len+1 zero-data R beats per read, so the upstream manager always sees a protocol-complete, error-flagged transaction. Read and write channels are handled by independent state machines.

## Interface
Parameters:
- IdWidth, 4, width of AXI ID fields
- DataWidth, 64, width of R data
- Resp, axi_conf::RESP_DECERR, response code returned on B and R; must be RESP_SLVERR or RESP_DECERR (elaboration assertion)

Ports (one clock; reset is asynchronous and active-low):
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- aw_valid_i  in  1  write address valid
- aw_ready_o  out  1  write address ready
- aw_id_i  in  IdWidth  write transaction ID
- w_valid_i  in  1  write data valid
- w_ready_o  out  1  write data ready
- w_last_i  in  1  last write beat
- b_valid_o  out  1  write response valid
- b_ready_i  in  1  write response ready
- b_id_o  out  IdWidth  write response ID
- b_resp_o  out  2  write response code (axi_conf::axi_trans_resp_t)
- ar_valid_i  in  1  read address valid
- ar_ready_o  out  1  read address ready
- ar_id_i  in  IdWidth  read transaction ID
- ar_len_i  in  8  read burst length minus one
- r_valid_o  out  1  read data valid
- r_ready_i  in  1  read data ready
- r_id_o  out  IdWidth  read data ID
- r_data_o  out  DataWidth  read data, constant 0
- r_resp_o  out  2  read response code
- r_last_o  out  1  last read beat

## Operation
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: aw_ready_o=1. On aw_valid_i, store aw_id_i and go to W_DATA.
  - W_DATA: w_ready_o=1. Discard beats. On w_valid_i && w_last_i, go to W_RESP.
  - W_RESP: b_valid_o=1, b_id_o=stored ID, b_resp_o=Resp. On b_ready_i, go to W_IDLE.
- W beats arriving before AW are not accepted; they wait for w_ready_o, which is legal AXI behaviour.
- Read FSM, states R_IDLE, R_DATA:
  - R_IDLE: ar_ready_o=1. On ar_valid_i, store ar_id_i, load the 8-bit beat counter with ar_len_i, and go to R_DATA.
  - R_DATA: r_valid_o=1, r_resp_o=Resp, r_data_o=0, r_last_o=(counter==0).
    - Handshake with counter!=0: decrement the counter.
    - Handshake with counter==0: go to R_IDLE.
- One outstanding transaction per direction; no ID reordering is needed.
- The two FSMs share no state. Simultaneous AW and AR are both accepted in the same cycle.

## Timing
- Reset values: aw_ready_o=1, ar_ready_o=1; w_ready_o, b_valid_o, r_valid_o, r_last_o=0. b_id_o, r_id_o, r_data_o=0. b_resp_o and r_resp_o carry Resp.
- All outputs are decoded from registered state. There is no combinational path from any input to any output.
- AW handshake in cycle n: w_ready_o=1 from cycle n+1.
- Last W handshake in cycle m: b_valid_o=1 from cycle m+1. It stays high until the b_ready_i handshake, with stable ID and response.
- AR handshake in cycle n: first R beat valid in cycle n+1. With r_ready_i held high, beats are back-to-back and the last beat is in cycle n+1+ar_len_i.
- ar_ready_o is 0 from n+1 until the cycle after the last R handshake.
- ar_len_i=0 gives a single beat with r_last_o=1. ar_len_i=255 gives 256 beats; the counter does not wrap, because it stops at 0.
- r_valid_o, r_id_o and r_last_o are held stable while r_ready_i=0.
- Reset asserted mid-burst: both FSMs return to IDLE immediately (asynchronously). The burst in flight is abandoned.

## Structure
- axi_trans_resp_t lives in the shared package axi_conf. Add the write/read FSM state enums there too, as axi_err_wstate_e and axi_err_rstate_e.
- No sub-module: one module with two independent sequential processes, one for write and one for read.

## Test plan
- Reset -> aw_ready_o=1, ar_ready_o=1, all valids 0, b_resp_o=r_resp_o=2'b11.
- AW id=3, then 4 W beats with w_last on the 4th, b_ready_i=1 -> b_valid_o exactly one cycle after the 4th W handshake; b_id_o=3, b_resp_o=2'b11.
- AR id=5, len=7, r_ready_i=1 -> 8 consecutive beats in cycles 1..8 after the handshake; r_id_o=5, r_data_o=0, r_last_o only on beat 8, r_resp_o=2'b11.
- Resp=RESP_SLVERR; b_ready_i low for 5 cycles and r_ready_i toggling every cycle -> b_valid_o held for 5 cycles with aw_ready_o=0; R beats advance only on handshakes; all responses 2'b10.
- AW id=1 and AR id=2 with len=0 in the same cycle -> both accepted; a single R beat with r_last_o=1 and id=2 in the next cycle; the write path is unaffected.
- rst_ni pulsed low during beat 3 of an 8-beat read -> all outputs take reset values immediately; a new AR with len=1 afterwards returns exactly 2 beats.
